pcs_tx_enc: RTL and testbench
=============================

# pcs_tx_enc

64b/66b transmit encoder sitting directly downstream of the Ethernet TX pipe and upstream of the 66→64 gearbox. It consumes the MAC's DATA_W-wide beat stream with its start/idle/term side-band, assembles BLOCK_N-byte blocks, and emits one clause-49 encoded 66-bit block (2-bit sync header, 64-bit payload) per block time. It also drives the back-pressure `ready` that the MAC stream stalls on.

## Interface
- DATA_W, 16, beat width; one of 16/32/64
- BLOCK_N, 8, bytes per block
- BEAT_N, BLOCK_N*8/DATA_W, beats per block
- BLOCK_LEN_W, $clog2(BLOCK_N+1), term length width
- LANE0_CNT_N, (DATA_W==64)?2:1, start-position lanes
- clk  in  1  clock
- nreset  in  1  reset; synchronous, active-low
- ctrl_v_i  in  1  beat carries control information
- data_i  in  DATA_W  beat data; byte 0 in bits [7:0]
- start_i  in  LANE0_CNT_N  bit0: start in lane 0; bit1: start in lane 4
- idle_i  in  1  no frame data this block
- term_i  in  1  terminate block
- term_len_i  in  BLOCK_LEN_W  valid data bytes in terminate block, 0..7
- ready_o  out  1  beat accepted this cycle
- gb_ready_i  in  1  gearbox accepts; low one cycle per 32 blocks
- block_v_o  out  1  block output valid, one-cycle pulse
- head_o  out  2  sync header
- block_o  out  64  payload, type byte in [7:0]

## Operation
- ready_o = gb_ready_i (combinational). Beat consumed iff ready_o; when low, beat counter and lane buffer hold.
- Beat counter 0..BEAT_N-1, wraps; beats 0..BEAT_N-2 stored in lane buffer, final beat combined combinationally into raw bytes b0..b7.
- Block class captured from beat 0: start_i, idle_i, term_i, term_len_i; later-beat side-band ignored except error check.
- Encoding (raw → head/payload):
  - data (no flag, ctrl_v_i low): head 01, payload = raw.
  - start lane 0: head 10, byte0 = 0x78, bytes1-7 = b1..b7 (b0 preamble byte dropped).
  - start lane 4 (DATA_W=64 only): head 10, type 0x33, four 7-bit idle codes 0, 4-bit pad 0, then b5..b7.
  - term n: head 10, type T0..T7 = 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF; bytes 1..n = b0..b(n-1); remaining bits 0.
  - idle: head 10, payload {56'h0, 8'h1E}.
  - error: head 10, type 0x1E, eight 7-bit /E/ codes 7'h1E.
- Error class when any: start & term at beat 0; idle with start or term; term_len_i > 7; start_i nonzero on beat ≠ 0; start_i[1] when DATA_W≠64.
- Output registered; block_v_o high one cycle per completed block.

## Timing
- Reset: block_v_o 0, head_o 2'b00, block_o 0, beat counter 0, lane buffer don't-care, scrambler state all ones.
- Latency: final beat accepted at cycle t → block_v_o/head_o/block_o at t+1.
- gb_ready_i low on final beat: block not completed, no pulse; completes on next ready cycle.
- nreset mid-block: partial block discarded, counter to 0, next accepted beat is beat 0.
- Back-to-back blocks: block_v_o every BEAT_N ready cycles; DATA_W=64 → every ready cycle.

## Configuration
- PCS_TX_SCRAMBLE_EN defined: payload passes self-synchronous scrambler x^58+x^39+1, LSB first, before output register; header never scrambled; state advances only on emitted blocks.
- Undefined: payload emitted unscrambled (debug/loopback); scrambler not instantiated.

## Structure
- Shared package pcs_pkg: block type constants (0x78, 0x33, 0x1E, T0..T7), sync header constants, /E/ code, block class enum.
- One sub-module: pcs_scrambler (64-bit parallel, 58-bit state, enable input).

## Test plan
- DATA_W=16, idle_i high 4 beats → head 10, block_o 64'h1E, one pulse per 4 cycles.
- Start lane 0, beats 0x5555×3, 0xD555 → head 10, block_o 64'hD555555555555578.
- Data beats 0x0201,0x0403,0x0605,0x0807 → head 01, block_o 64'h0807060504030201, pulse cycle after 4th beat.
- term_len_i=3, b0..b2 = AA,BB,CC → block_o 64'h00000000CCBBAAB4; n=0 → 64'h87.
- start & term at beat 0 → error block 0x1E type with /E/ codes; gb_ready_i low on beat 3 → output delayed exactly one cycle.
- PCS_TX_SCRAMBLE_EN: 1000 random blocks through pcs_scrambler + reference descrambler → original payloads recovered, headers unchanged.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 64b/66b encoder definitions: sync headers, block type bytes, /E/ and idle codes,
// and the block classification enum used by pcs_tx_enc.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] TYPE_START0 = 8'h78;
  localparam logic [7:0] TYPE_START4 = 8'h33;
  localparam logic [7:0] TYPE_CTRL   = 8'h1E;

  localparam logic [7:0] TYPE_T0 = 8'h87;
  localparam logic [7:0] TYPE_T1 = 8'h99;
  localparam logic [7:0] TYPE_T2 = 8'hAA;
  localparam logic [7:0] TYPE_T3 = 8'hB4;
  localparam logic [7:0] TYPE_T4 = 8'hCC;
  localparam logic [7:0] TYPE_T5 = 8'hD2;
  localparam logic [7:0] TYPE_T6 = 8'hE1;
  localparam logic [7:0] TYPE_T7 = 8'hFF;

  localparam logic [6:0] CODE_ERROR = 7'h1E;
  localparam logic [6:0] CODE_IDLE  = 7'h00;

  typedef enum logic [2:0] {
    CLS_DATA,
    CLS_START0,
    CLS_START4,
    CLS_TERM,
    CLS_IDLE,
    CLS_ERROR
  } blk_class_e;

  function automatic logic [7:0] term_type(input logic [2:0] n);
    case (n)
      3'd0:    return TYPE_T0;
      3'd1:    return TYPE_T1;
      3'd2:    return TYPE_T2;
      3'd3:    return TYPE_T3;
      3'd4:    return TYPE_T4;
      3'd5:    return TYPE_T5;
      3'd6:    return TYPE_T6;
      default: return TYPE_T7;
    endcase
  endfunction

endpackage

// File: rtl/pcs_scrambler.sv
// 64-bit parallel self-synchronous scrambler, polynomial x^58 + x^39 + 1, bit 0 sent first.
// State holds the last 58 scrambled bits (bit 0 newest) and only advances when en is high.
module pcs_scrambler
  import pcs_pkg::*;
(
  input  logic        clk,
  input  logic        nreset,
  input  logic        en,
  input  logic [63:0] data,
  output logic [63:0] scrambled
);

  logic [57:0] state;
  logic [57:0] state_next;

  always_comb begin
    state_next = state;
    scrambled  = '0;
    for (int i = 0; i < 64; i++) begin
      scrambled[i] = data[i] ^ state_next[38] ^ state_next[57];
      state_next   = {state_next[56:0], scrambled[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= '1;
    end else if (en) begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/pcs_tx_enc.sv
// 64b/66b transmit encoder: gathers MAC beats into 8-byte blocks and emits one 66-bit block each.
// Define PCS_TX_SCRAMBLE_EN to scramble the payload; otherwise the payload leaves unscrambled.
module pcs_tx_enc
  import pcs_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int BLOCK_N     = 8,
  parameter int BEAT_N      = BLOCK_N * 8 / DATA_W,
  parameter int BLOCK_LEN_W = $clog2(BLOCK_N + 1),
  parameter int LANE0_CNT_N = (DATA_W == 64) ? 2 : 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   ctrl_v_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [LANE0_CNT_N-1:0] start_i,
  input  logic                   idle_i,
  input  logic                   term_i,
  input  logic [BLOCK_LEN_W-1:0] term_len_i,
  output logic                   ready_o,
  input  logic                   gb_ready_i,
  output logic                   block_v_o,
  output logic [1:0]             head_o,
  output logic [63:0]            block_o
);

  localparam int CNT_W = (BEAT_N > 1) ? $clog2(BEAT_N) : 1;

  logic [CNT_W-1:0]       beat_cnt;
  logic [63:0]            lane_buf;
  logic [63:0]            raw;
  logic [1:0]             start_x;
  logic                   last;
  logic                   done;
  logic                   late_err;
  blk_class_e             cls0;
  blk_class_e             cls_q;
  blk_class_e             blk_class;
  logic                   err_q;
  logic [BLOCK_LEN_W-1:0] len_q;
  logic [BLOCK_LEN_W-1:0] blk_len;
  logic [1:0]             enc_head;
  logic [63:0]            enc_payload;
  logic [63:0]            out_payload;

  assign ready_o  = gb_ready_i;
  assign start_x  = 2'(start_i);
  assign last     = (beat_cnt == CNT_W'(BEAT_N - 1));
  assign done     = ready_o && last;
  assign late_err = ctrl_v_i && (start_x != 2'b00);

  // Side-band is only meaningful on a control beat; a control beat naming no class is an error.
  always_comb begin
    cls0 = CLS_DATA;
    if (ctrl_v_i) begin
      if ((start_x != 2'b00 && term_i) ||
          (idle_i && (start_x != 2'b00 || term_i)) ||
          (term_i && term_len_i > BLOCK_LEN_W'(BLOCK_N - 1)) ||
          (start_x == 2'b11) ||
          (start_x[1] && DATA_W != 64)) begin
        cls0 = CLS_ERROR;
      end else if (start_x[0]) begin
        cls0 = CLS_START0;
      end else if (start_x[1]) begin
        cls0 = CLS_START4;
      end else if (term_i) begin
        cls0 = CLS_TERM;
      end else if (idle_i) begin
        cls0 = CLS_IDLE;
      end else begin
        cls0 = CLS_ERROR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      beat_cnt <= '0;
      cls_q    <= CLS_DATA;
      err_q    <= 1'b0;
      len_q    <= '0;
    end else if (ready_o) begin
      beat_cnt <= last ? '0 : beat_cnt + 1'b1;
      if (beat_cnt == '0) begin
        cls_q <= cls0;
        len_q <= term_len_i;
        err_q <= 1'b0;
      end else if (late_err) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ready_o && !last) begin
      lane_buf[int'(beat_cnt)*DATA_W +: DATA_W] <= data_i;
    end
  end

  always_comb begin
    raw = lane_buf;
    raw[(BEAT_N-1)*DATA_W +: DATA_W] = data_i;
  end

  // With a single beat per block the beat-0 decode is the live one.
  always_comb begin
    blk_class = (beat_cnt == '0) ? cls0 : cls_q;
    blk_len   = (beat_cnt == '0) ? term_len_i : len_q;
    if (beat_cnt != '0 && (err_q || late_err)) begin
      blk_class = CLS_ERROR;
    end
  end

  always_comb begin
    enc_head    = SYNC_CTRL;
    enc_payload = '0;
    case (blk_class)
      CLS_DATA: begin
        enc_head    = SYNC_DATA;
        enc_payload = raw;
      end
      CLS_START0: enc_payload = {raw[63:8], TYPE_START0};
      CLS_START4: enc_payload = {raw[63:40], 4'h0, {4{CODE_IDLE}}, TYPE_START4};
      CLS_TERM: begin
        enc_payload[7:0] = term_type(blk_len[2:0]);
        for (int i = 0; i < 7; i++) begin
          if (i < int'(blk_len)) begin
            enc_payload[8*i+8 +: 8] = raw[8*i +: 8];
          end
        end
      end
      CLS_IDLE: enc_payload = {56'h0, TYPE_CTRL};
      default:  enc_payload = {{8{CODE_ERROR}}, TYPE_CTRL};
    endcase
  end

`ifdef PCS_TX_SCRAMBLE_EN
  pcs_scrambler u_scrambler (
    .clk       (clk),
    .nreset    (nreset),
    .en        (done),
    .data      (enc_payload),
    .scrambled (out_payload)
  );
`else
  assign out_payload = enc_payload;
`endif

  always_ff @(posedge clk) begin
    if (!nreset) begin
      block_v_o <= 1'b0;
      head_o    <= 2'b00;
      block_o   <= '0;
    end else begin
      block_v_o <= done;
      if (done) begin
        head_o  <= enc_head;
        block_o <= out_payload;
      end
    end
  end

endmodule

// File: tb/tb_pcs_tx_enc.sv
// Testbench for pcs_tx_enc (DATA_W=16): directed vector table plus randomized blocks against a
// byte-level reference model; with PCS_TX_SCRAMBLE_EN outputs are descrambled before comparison.
module tb_pcs_tx_enc;

  localparam int DATA_W = 16;
  localparam int BEAT_N = 4;

`ifdef PCS_TX_SCRAMBLE_EN
  localparam int N_RAND = 1000;
`else
  localparam int N_RAND = 300;
`endif

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        ctrl_v_i = 1'b0;
  logic [15:0] data_i = '0;
  logic [0:0]  start_i = '0;
  logic        idle_i = 1'b0;
  logic        term_i = 1'b0;
  logic [3:0]  term_len_i = '0;
  logic        gb_ready_i = 1'b1;
  logic        ready_o;
  logic        block_v_o;
  logic [1:0]  head_o;
  logic [63:0] block_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tt [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  typedef struct {
    logic [63:0] raw;
    logic        ctrl;
    logic        start;
    logic        idle;
    logic        term;
    logic [3:0]  len;
    int          late;
    int          stall;
    logic [1:0]  exp_head;
    logic [63:0] exp_block;
  } vec_t;

  always #5 clk = ~clk;

  pcs_tx_enc dut (
    .clk        (clk),
    .nreset     (nreset),
    .ctrl_v_i   (ctrl_v_i),
    .data_i     (data_i),
    .start_i    (start_i),
    .idle_i     (idle_i),
    .term_i     (term_i),
    .term_len_i (term_len_i),
    .ready_o    (ready_o),
    .gb_ready_i (gb_ready_i),
    .block_v_o  (block_v_o),
    .head_o     (head_o),
    .block_o    (block_o)
  );

`ifdef PCS_TX_SCRAMBLE_EN
  bit hist[$];

  task automatic reset_hist();
    hist.delete();
    repeat (58) hist.push_back(1'b1);
  endtask

  // Reference descrambler: each plain bit is the line bit XOR line bits 39 and 58 earlier.
  function automatic logic [63:0] descramble(input logic [63:0] s);
    logic [63:0] d;
    for (int i = 0; i < 64; i++) begin
      d[i] = s[i] ^ hist[hist.size()-39] ^ hist[hist.size()-58];
      hist.push_back(s[i]);
      void'(hist.pop_front());
    end
    return d;
  endfunction
`else
  task automatic reset_hist();
  endtask

  function automatic logic [63:0] descramble(input logic [63:0] s);
    return s;
  endfunction
`endif

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] raw, input logic ctrl, input logic start,
                              input logic idle, input logic term, input logic [3:0] len,
                              input int late, input int stall, input logic [1:0] eh,
                              input logic [63:0] eb);
    vec_t v;
    v.raw = raw; v.ctrl = ctrl; v.start = start; v.idle = idle; v.term = term;
    v.len = len; v.late = late; v.stall = stall; v.exp_head = eh; v.exp_block = eb;
    return v;
  endfunction

  // Expected block from the encoding rules, working on the eight raw bytes.
  function automatic vec_t model(input vec_t v);
    logic [7:0]  b [8];
    logic        bad;
    logic [63:0] p;
    vec_t        r;
    r = v;
    for (int i = 0; i < 8; i++) b[i] = v.raw[8*i +: 8];
    bad = (v.late != 0);
    if (v.ctrl)
      bad = bad || (v.start && v.term) || (v.idle && (v.start || v.term)) ||
            (v.term && v.len > 7) || !(v.start || v.idle || v.term);
    r.exp_head = 2'b10;
    p = '0;
    if (bad) begin
      p[7:0] = 8'h1E;
      for (int i = 0; i < 8; i++) p[8+7*i +: 7] = 7'h1E;
    end else if (!v.ctrl) begin
      r.exp_head = 2'b01;
      p = v.raw;
    end else if (v.start) begin
      p[7:0] = 8'h78;
      for (int i = 1; i < 8; i++) p[8*i +: 8] = b[i];
    end else if (v.term) begin
      p[7:0] = tt[v.len[2:0]];
      for (int i = 0; i < int'(v.len); i++) p[8*(i+1) +: 8] = b[i];
    end else begin
      p[7:0] = 8'h1E;
    end
    r.exp_block = p;
    return r;
  endfunction

  task automatic do_reset();
    nreset = 1'b0;
    gb_ready_i = 1'b1;
    ctrl_v_i = 1'b0; start_i = '0; idle_i = 1'b0; term_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset valid", 64'(block_v_o), 64'd0);
    check_val("reset head", 64'(head_o), 64'd0);
    check_val("reset block", block_o, 64'd0);
    nreset = 1'b1;
    reset_hist();
  endtask

  task automatic drive_beat(input vec_t v, input int k);
    data_i     = v.raw[16*k +: 16];
    ctrl_v_i   = (k == 0) ? v.ctrl : (k == v.late);
    start_i    = (k == 0) ? v.start : (k == v.late);
    idle_i     = v.idle;
    term_i     = (k == 0) ? v.term : 1'b0;
    term_len_i = (k == 0) ? v.len : 4'($urandom_range(0, 7));
  endtask

  task automatic check_output(input string name, input vec_t v);
    logic [63:0] plain;
    check_val({name, " valid"}, 64'(block_v_o), 64'd1);
    plain = block_v_o ? descramble(block_o) : block_o;
    check_val({name, " head"}, 64'(head_o), 64'(v.exp_head));
    check_val({name, " block"}, plain, v.exp_block);
  endtask

  task automatic apply_stimulus(input string name, input vec_t v);
    for (int k = 0; k < BEAT_N; k++) begin
      drive_beat(v, k);
      if (k == v.stall) begin
        gb_ready_i = 1'b0;
        #1;
        check_val({name, " ready low"}, 64'(ready_o), 64'd0);
        @(posedge clk);
        #1;
        check_val({name, " stalled pulse"}, 64'(block_v_o), 64'd0);
        gb_ready_i = 1'b1;
        #1;
        check_val({name, " ready high"}, 64'(ready_o), 64'd1);
      end
      @(posedge clk);
      #1;
      if (k == BEAT_N - 1) check_output(name, v);
      else check_val({name, " early pulse"}, 64'(block_v_o), 64'd0);
    end
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    tbl[0]  = mk(64'h0123456789ABCDEF, 1, 0, 1, 0, 4'd0, 0, -1, 2'b10, 64'h000000000000001E);
    tbl[1]  = mk(64'hD555555555555555, 1, 1, 0, 0, 4'd0, 0, -1, 2'b10, 64'hD555555555555578);
    tbl[2]  = mk(64'h0807060504030201, 0, 0, 0, 0, 4'd0, 0, -1, 2'b01, 64'h0807060504030201);
    tbl[3]  = mk(64'h1122334455CCBBAA, 1, 0, 0, 1, 4'd3, 0, -1, 2'b10, 64'h00000000CCBBAAB4);
    tbl[4]  = mk(64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 1, 4'd0, 0, -1, 2'b10, 64'h0000000000000087);
    tbl[5]  = mk(64'h0807060504030201, 1, 0, 0, 1, 4'd7, 0, -1, 2'b10, 64'h07060504030201FF);
    tbl[6]  = mk(64'h5555555555555555, 1, 1, 0, 1, 4'd2, 0,  3, 2'b10, 64'h3C78F1E3C78F1E1E);
    tbl[7]  = mk(64'h0000000000000000, 1, 0, 1, 1, 4'd1, 0, -1, 2'b10, 64'h3C78F1E3C78F1E1E);
    tbl[8]  = mk(64'h1111111111111111, 1, 0, 0, 1, 4'd9, 0, -1, 2'b10, 64'h3C78F1E3C78F1E1E);
    tbl[9]  = mk(64'h0807060504030201, 0, 0, 0, 0, 4'd0, 2, -1, 2'b10, 64'h3C78F1E3C78F1E1E);
    tbl[10] = mk(64'hDEAD00EEDDCCBBAA, 1, 0, 0, 1, 4'd5, 0,  1, 2'b10, 64'h0000EEDDCCBBAAD2);
    tbl[11] = mk(64'hCAFEBABE12345678, 1, 1, 1, 0, 4'd0, 0, -1, 2'b10, 64'h3C78F1E3C78F1E1E);

    do_reset();

    for (int i = 0; i < 12; i++) apply_stimulus($sformatf("vec%0d", i), tbl[i]);

    // Reset in the middle of a block: the partial start block must vanish entirely.
    for (int k = 0; k < 2; k++) begin
      drive_beat(tbl[1], k);
      @(posedge clk);
      #1;
    end
    nreset = 1'b0;
    @(posedge clk);
    #1;
    check_val("midreset valid", 64'(block_v_o), 64'd0);
    check_val("midreset block", block_o, 64'd0);
    nreset = 1'b1;
    reset_hist();
    apply_stimulus("after midreset", tbl[2]);

    for (int n = 0; n < N_RAND; n++) begin
      v = mk({$urandom, $urandom}, ($urandom % 3) != 0, 0, 0, 0, 4'($urandom_range(0, 7)),
             0, -1, 2'b00, 64'd0);
      if (v.ctrl) begin
        case ($urandom % 8)
          0, 1:    v.start = 1'b1;
          2, 3:    v.term = 1'b1;
          4, 5:    v.idle = 1'b1;
          6: begin
            v.start = 1'($urandom);
            v.idle  = 1'($urandom);
            v.term  = 1'($urandom);
            if (!(v.start || v.idle || v.term)) v.idle = 1'b1;
          end
          default: begin
            v.term = 1'b1;
            v.len  = 4'($urandom_range(0, 15));
          end
        endcase
      end
      if ($urandom % 16 == 0) v.late = $urandom_range(1, 3);
      if ($urandom % 8 == 0) v.stall = $urandom_range(0, 3);
      v = model(v);
      apply_stimulus($sformatf("rand%0d", n), v);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
